muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide unit; sits beside the combinational ALU in the EX stage.
//  Accepts one M-extension op per start pulse and raises busy while it works.
//  busy is ORed into the pipeline busywait so IF/ID/EX/MEM/WB registers stall until done.
//  Generalises the single-cycle ALU path in operand width (XLEN) and in bits retired per cycle.
// PARAMETERS
//  XLEN            32  operand/result width; even, >= 8
//  BITS_PER_CYCLE  1   quotient/multiplier bits retired per CALC cycle; one of 1, 2, 4; must divide XLEN
// PORTS
//  clk     in   1     clock, rising edge
//  rst     in   1     reset; asynchronous, active-low
//  start   in   1     launch op; sampled only in IDLE or DONE
//  op      in   3     funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//  a       in   XLEN  rs1 operand, captured with start
//  b       in   XLEN  rs2 operand, captured with start
//  flush   in   1     abort in-flight op (branch taken in EX)
//  busy    out  1     high in CALC and FIX
//  done    out  1     one-cycle pulse: result valid
//  result  out  XLEN  held from done until the next accepted start
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, busy=0, done=0, result=0, all internal regs 0.
//  - States: IDLE, CALC, FIX, DONE.
//  - Acceptance: start=1 in IDLE or DONE captures op/a/b at that edge (E0).
//    DONE->CALC back-to-back is legal. start in CALC/FIX is ignored.
//  - Normal path:
//      E0 -> CALC; N = XLEN/BITS_PER_CYCLE CALC cycles.
//      -> FIX: sign correction; select hi/lo or quotient/remainder.
//      -> DONE: done=1 for one cycle; result valid.
//    done is high in the cycle after edge N+1. XLEN=32/BPC=1: 33 edges.
//  - Next state from DONE: IDLE, or CALC if start=1.
//  - Fast path from IDLE/DONE straight to DONE at E0 (done in the cycle after E0):
//      div by zero (b==0): DIV/DIVU q = all-ones; REM/REMU r = a.
//      signed overflow (a == 1<<(XLEN-1), b == all-ones):
//        DIV q = a; REM r = 0.
//  - Multiply:
//      operands converted to magnitudes per op signedness (MULHSU: a signed, b unsigned).
//      2*XLEN-bit shift-add product.
//      Negated in FIX if exactly one signed operand is negative.
//      MUL returns low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits.
//  - Divide:
//      restoring, on magnitudes.
//      Quotient negated if signs differ (signed ops).
//      Remainder takes the sign of a.
//  - All arithmetic is modulo 2^XLEN on result; no exceptions or flags.
//  - flush:
//      in CALC/FIX: next edge -> IDLE, busy=0, no done, result unchanged.
//      in IDLE/DONE: ignored.
//      flush together with start: flush wins; op not accepted.
//  - rst asserted mid-operation: immediate return to reset values; no done.
// STRUCTURE
//  - muldiv_pkg: op localparams (funct3 codes), state encoding, helper is_signed_a/is_signed_b.
//  - Sub-module muldiv_step (combinational):
//      one BITS_PER_CYCLE slice of shift-add / restoring-subtract.
//      Instantiated once, iterated by the FSM.
//  - Top holds:
//      FSM, iteration counter ($clog2(XLEN/BITS_PER_CYCLE+1) bits),
//      2*XLEN accumulator, divisor/multiplicand reg, sign flags.
// TESTING
//  1. MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB; done exactly 33 edges after start (BPC=1).
//  2. MULH a=b=0x80000000 -> 0x40000000.
//     MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE.
//     MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
//  3. DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD.
//     REM same -> 0xFFFFFFFF.
//     DIVU a=100, b=7 -> 14; REMU -> 2.
//  4. DIV a=5, b=0 -> 0xFFFFFFFF; REMU a=5, b=0 -> 5.
//     DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM -> 0.
//     All four: done in the cycle after the start edge.
//  5. start DIVU, flush at CALC cycle 10 -> IDLE next edge, no done, result keeps previous value.
//     Then start in the same cycle as flush -> not accepted.
//  6. rst=0 mid-CALC -> busy/done/result 0 immediately.
//     Re-run with BITS_PER_CYCLE=2 and =4: MUL 7*-3 -> done after 17 and 9 edges.
//     Back-to-back start in DONE -> second op accepted with no IDLE gap.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 op codes, FSM state type and operand-signedness helpers.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  // MUL keeps only the low half, which is identical for any signedness.
  function automatic logic is_signed_a(input logic [2:0] op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(input logic [2:0] op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One BITS_PER_CYCLE slice of shift-add multiply or restoring divide on the
// 2*XLEN accumulator {hi, lo}; purely combinational.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic              i_div,
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_opnd,
  output logic [2*XLEN-1:0] o_acc
);

  logic [2*XLEN-1:0] w_acc;
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_rem;
  logic [XLEN-1:0]   w_diff;

  always_comb begin
    w_acc  = i_acc;
    w_sum  = '0;
    w_rem  = '0;
    w_diff = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (i_div) begin
        // Shifted partial remainder can need XLEN+1 bits before the subtract.
        w_rem = w_acc[2*XLEN-1:XLEN-1];
        if (w_rem >= {1'b0, i_opnd}) begin
          w_diff = w_rem[XLEN-1:0] - i_opnd;
          w_acc  = {w_diff, w_acc[XLEN-2:0], 1'b1};
        end else begin
          w_acc  = {w_rem[XLEN-1:0], w_acc[XLEN-2:0], 1'b0};
        end
      end else begin
        w_sum = {1'b0, w_acc[2*XLEN-1:XLEN]} + (w_acc[0] ? {1'b0, i_opnd} : '0);
        w_acc = {w_sum, w_acc[XLEN-1:1]};
      end
    end
    o_acc = w_acc;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: IDLE -> CALC (XLEN/BITS_PER_CYCLE
// cycles) -> FIX -> DONE, with a fast path for divide-by-zero and overflow.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned N     = XLEN / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = $clog2(N + 1);

  state_t              r_state, w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_opnd;
  logic [2:0]          r_op;
  logic                r_neg;
  logic [XLEN-1:0]     r_result;

  logic                w_accept, w_a_neg, w_b_neg, w_dbz, w_ovf, w_fast;
  logic [XLEN-1:0]     w_mag_a, w_mag_b, w_fast_res, w_fix_res, w_quo, w_rem;
  logic [2*XLEN-1:0]   w_step_acc, w_prod;

  assign w_accept = start & ~flush & ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_a_neg  = is_signed_a(op) & a[XLEN-1];
  assign w_b_neg  = is_signed_b(op) & b[XLEN-1];
  assign w_mag_a  = w_a_neg ? (~a + XLEN'(1)) : a;
  assign w_mag_b  = w_b_neg ? (~b + XLEN'(1)) : b;
  assign w_dbz    = op[2] & (b == '0);
  assign w_ovf    = (op == OP_DIV || op == OP_REM) & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
  assign w_fast   = w_dbz | w_ovf;

  always_comb begin
    w_fast_res = '0;
    if (w_dbz)      w_fast_res = op[1] ? a : '1;
    else if (w_ovf) w_fast_res = op[1] ? '0 : a;
  end

  muldiv_step #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .i_div  (r_op[2]),
    .i_acc  (r_acc),
    .i_opnd (r_opnd),
    .o_acc  (w_step_acc)
  );

  always_comb begin
    w_prod    = r_neg ? (~r_acc + (2*XLEN)'(1)) : r_acc;
    w_quo     = r_neg ? (~r_acc[XLEN-1:0] + XLEN'(1)) : r_acc[XLEN-1:0];
    w_rem     = r_neg ? (~r_acc[2*XLEN-1:XLEN] + XLEN'(1)) : r_acc[2*XLEN-1:XLEN];
    w_fix_res = '0;
    if (r_op[2])              w_fix_res = r_op[1] ? w_rem : w_quo;
    else if (r_op == OP_MUL)  w_fix_res = w_prod[XLEN-1:0];
    else                      w_fix_res = w_prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_fast ? S_DONE : S_CALC;
      S_CALC: begin
        busy = 1'b1;
        if (flush)                            w_next = S_IDLE;
        else if (r_cnt == CNT_W'(N - 1))      w_next = S_FIX;
      end
      S_FIX: begin
        busy   = 1'b1;
        w_next = flush ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = w_accept ? (w_fast ? S_DONE : S_CALC) : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op  <= op;
      r_cnt <= '0;
      if (w_fast) begin
        r_result <= w_fast_res;
      end else begin
        // Divide iterates the dividend through lo; multiply iterates the multiplier.
        r_acc  <= {{XLEN{1'b0}}, (op[2] ? w_mag_a : w_mag_b)};
        r_opnd <= op[2] ? w_mag_b : w_mag_a;
        r_neg  <= (op[2] & op[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
      end
    end else if (r_state == S_CALC) begin
      r_acc <= w_step_acc;
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (r_state == S_FIX && !flush) begin
      r_result <= w_fix_res;
    end
  end

  assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit at BITS_PER_CYCLE 1, 2 and 4 against an
// arithmetic reference model and a cycle-level expectation of done/busy/result.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_v [3];
  logic        flush_v [3];
  logic [2:0]  op_v    [3];
  logic [31:0] a_v     [3];
  logic [31:0] b_v     [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic [31:0] result_v[3];

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  // expectation model per DUT
  int          done_at  [3];
  int          busy_from[3];
  int          busy_to  [3];
  logic [31:0] pend     [3];
  logic [31:0] held     [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .op(op_v[0]), .a(a_v[0]), .b(b_v[0]),
    .flush(flush_v[0]), .busy(busy_v[0]), .done(done_v[0]), .result(result_v[0]));
  muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_v[1]), .op(op_v[1]), .a(a_v[1]), .b(b_v[1]),
    .flush(flush_v[1]), .busy(busy_v[1]), .done(done_v[1]), .result(result_v[1]));
  muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start_v[2]), .op(op_v[2]), .a(a_v[2]), .b(b_v[2]),
    .flush(flush_v[2]), .busy(busy_v[2]), .done(done_v[2]), .result(result_v[2]));

  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, ux, uy;
    logic [63:0] p;
    logic ovf;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    ux  = longint'({32'b0, x});
    uy  = longint'({32'b0, y});
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    p   = '0;
    case (o)
      3'd0: begin p = ux * uy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: if (y == 0) return 32'hFFFF_FFFF; else if (ovf) return x;
            else return 32'($signed(x) / $signed(y));
      3'd5: if (y == 0) return 32'hFFFF_FFFF; else return x / y;
      3'd6: if (y == 0) return x; else if (ovf) return 32'd0;
            else return 32'($signed(x) % $signed(y));
      default: if (y == 0) return x; else return x % y;
    endcase
  endfunction

  function automatic logic ref_fast(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    return o[2] && ((y == 0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    logic want_done, want_busy;
    for (int k = 0; k < 3; k++) begin
      want_done = (cyc == done_at[k]);
      want_busy = (cyc >= busy_from[k]) && (cyc < busy_to[k]);
      if (want_done) held[k] = pend[k];
      chk($sformatf("done[%0d]", k), 64'(done_v[k]), 64'(want_done));
      chk($sformatf("busy[%0d]", k), 64'(busy_v[k]), 64'(want_busy));
      chk($sformatf("result[%0d]", k), 64'(result_v[k]), 64'(held[k]));
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      done_at[k] = -1; busy_from[k] = 0; busy_to[k] = 0; held[k] = '0; pend[k] = '0;
    end
  endtask

  // Called at negedge+1; start is seen by the next rising edge.
  task automatic issue(input int k, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    int lat;
    lat = ref_fast(o, x, y) ? 0 : (32 >> k) + 1;
    op_v[k] = o; a_v[k] = x; b_v[k] = y; start_v[k] = 1'b1;
    pend[k]      = ref_res(o, x, y);
    busy_from[k] = cyc + 1;
    done_at[k]   = cyc + 1 + lat;
    busy_to[k]   = done_at[k];
    @(posedge clk);
    #1;
    start_v[k] = 1'b0;
    op_v[k] = 3'($urandom_range(0, 7)); a_v[k] = $urandom; b_v[k] = $urandom;
  endtask

  task automatic wait_done(input int k, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done_v[k]) begin
        dcyc = cyc;
        break;
      end
    end
    chk($sformatf("done_seen[%0d]", k), 64'(dcyc >= 0), 64'd1);
    #1;
  endtask

  task automatic run(input int k, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] exp, input int exp_lat, input string nm);
    int c0, d;
    c0 = cyc;
    issue(k, o, x, y);
    wait_done(k, d);
    chk(nm, 64'(result_v[k]), 64'(exp));
    chk({nm, "_latency"}, 64'(d - (c0 + 1)), 64'(exp_lat));
  endtask

  initial begin
    int c0;
    logic [2:0]  o;
    logic [31:0] x, y;
    int d;
    for (int k = 0; k < 3; k++) begin
      start_v[k] = 0; flush_v[k] = 0; op_v[k] = 0; a_v[k] = 0; b_v[k] = 0;
    end
    model_reset();
    fork
      forever begin
        @(negedge clk);
        compare();
      end
    join_none

    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_busy", 64'(busy_v[k]), 64'd0);
      chk("reset_done", 64'(done_v[k]), 64'd0);
      chk("reset_result", 64'(result_v[k]), 64'd0);
    end
    #1 rst = 1'b1;

    // pin the reference model with hand-computed values
    chk("model_mul",    64'(ref_res(3'd0, 32'd7, 32'hFFFF_FFFD)), 64'hFFFF_FFEB);
    chk("model_mulh",   64'(ref_res(3'd1, 32'h8000_0000, 32'h8000_0000)), 64'h4000_0000);
    chk("model_mulhsu", 64'(ref_res(3'd2, 32'hFFFF_FFFF, 32'd2)), 64'hFFFF_FFFF);
    chk("model_rem",    64'(ref_res(3'd6, 32'hFFFF_FFF9, 32'd2)), 64'hFFFF_FFFF);

    @(negedge clk); #1;
    // fast paths, then the normal path; all issued back-to-back from DONE
    run(0, 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, "div_by_zero");
    run(0, 3'd7, 32'd5, 32'd0, 32'd5, 0, "remu_by_zero");
    run(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, "div_overflow");
    run(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, "rem_overflow");
    run(0, 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul");
    run(0, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulh");
    run(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu");
    run(0, 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33, "mulhsu");
    run(0, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div");
    run(0, 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem");
    run(0, 3'd5, 32'd100, 32'd7, 32'd14, 33, "divu");
    run(0, 3'd7, 32'd100, 32'd7, 32'd2, 33, "remu");

    // flush during CALC cycle 10, then start+flush together in IDLE
    c0 = cyc;
    issue(0, 3'd5, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    #1;
    flush_v[0] = 1'b1;
    done_at[0] = -1;
    busy_to[0] = cyc + 1;
    @(posedge clk); #1 flush_v[0] = 1'b0;
    @(negedge clk);
    chk("flush_idle_busy", 64'(busy_v[0]), 64'd0);
    chk("flush_keep_result", 64'(result_v[0]), 64'd2);
    #1;
    op_v[0] = 3'd5; a_v[0] = 32'd50; b_v[0] = 32'd5; start_v[0] = 1'b1; flush_v[0] = 1'b1;
    @(posedge clk); #1 start_v[0] = 1'b0; flush_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("start_with_flush_busy", 64'(busy_v[0]), 64'd0);
    #1;

    // async reset in the middle of CALC
    issue(0, 3'd0, 32'd12345, 32'd678);
    repeat (5) @(negedge clk);
    #1;
    model_reset();
    rst = 1'b0;
    #1;
    chk("midreset_busy", 64'(busy_v[0]), 64'd0);
    chk("midreset_done", 64'(done_v[0]), 64'd0);
    chk("midreset_result", 64'(result_v[0]), 64'd0);
    @(posedge clk); @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk); #1;

    run(1, 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 17, "mul_bpc2");
    run(2, 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 9, "mul_bpc4");

    // randomized ops, mixing back-to-back issue and idle gaps
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 40; n++) begin
        o = 3'($urandom_range(0, 7));
        x = $urandom;
        y = $urandom;
        case ($urandom_range(0, 9))
          0: y = 32'd0;
          1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
          2: begin x = $urandom_range(0, 255); y = $urandom_range(1, 15); end
          3: begin x = -($urandom_range(1, 1000)); y = $urandom_range(1, 50); end
          4: y = -($urandom_range(1, 50));
          default: ;
        endcase
        issue(k, o, x, y);
        wait_done(k, d);
        chk($sformatf("rand[%0d] op%0d %h %h", k, o, x, y), 64'(result_v[k]), 64'(ref_res(o, x, y)));
        if ($urandom_range(0, 2) == 0) begin
          repeat ($urandom_range(1, 3)) @(negedge clk);
          #1;
        end
      end
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
